cic_rate_ctrl: RTL and testbench
================================

# cic_rate_ctrl

Sequencer and configuration controller for the CIC decimator. It owns the decimation rate R and produces the per-rate datapath constants (LOG2_D, Q, N). From the 18 MHz clock it generates the 6 MHz input-sample strobe and the decimated-output strobe. It applies rate changes safely: drain to a frame boundary, clear the filter, then hold output-valid low until the comb delay lines have refilled.

## Interface
Parameters:
- CLK_DIV, 3, clock cycles per input sample (18 MHz / 6 MHz)

Ports:
- clk  in  1  18 MHz system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request; low forces IDLE
- cfg_valid  in  1  rate-change request
- cfg_rate  in  5  requested R; legal values are 1, 2, 4, 8, 16
- cfg_ready  out  1  request accepted when high together with cfg_valid
- cfg_err  out  1  one-cycle pulse on an accepted illegal rate
- rate  out  5  active R
- log2_d  out  3  active LOG2_D
- q  out  3  active filter order Q
- n  out  3  active comb delay N
- in_en  out  1  input-sample strobe (integrator enable)
- dec_en  out  1  decimated-sample strobe (comb enable)
- out_valid  out  1  decimated sample is settled and valid
- cic_clr  out  1  filter state clear
- busy  out  1  high in DRAIN and FLUSH

## Operation
- Rate table (R: LOG2_D/Q/N/settle):
  - 1: 0/1/1/1
  - 2: 2/4/2/8
  - 4: 4/3/4/12
  - 8: 5/5/5/25
  - 16: 7/5/7/35
  - settle = Q·N
- States and transitions:
  - IDLE: strobes low, phase and sample counters at 0; enable=1 moves to SETTLE.
  - SETTLE: strobes run; settle_cnt counts dec_en pulses; the dec_en pulse that brings the count to settle moves to RUN.
  - RUN: out_valid = dec_en.
  - DRAIN: strobes run, out_valid=0; the next dec_en moves to FLUSH.
  - FLUSH: cic_clr=1 for exactly CLK_DIV cycles, strobes low, counters cleared, then SETTLE.
- cfg_ready = 1 in IDLE, SETTLE and RUN; 0 in DRAIN and FLUSH.
- Accepted illegal rate: cfg_err pulses on the next cycle; rate and state are unchanged.
- Accepted legal rate:
  - In IDLE: rate, log2_d, q and n update on the next cycle; state stays IDLE.
  - In SETTLE or RUN: the rate is latched as pending and the state moves to DRAIN.
  - The pending rate becomes active on entry to FLUSH.
- enable=0 in any state moves to IDLE on the next cycle. A pending rate is applied at that transition, and no cic_clr pulse is issued.
- cfg_valid and enable falling in the same cycle: the request is handled as if in IDLE.
- A same-rate request still runs DRAIN, FLUSH and SETTLE.
- Counter widths:
  - phase: 2 bits, wraps at CLK_DIV-1
  - sample_cnt: 4 bits, wraps at R-1
  - settle_cnt: 6 bits
  - No counter overflows at R=16.

## Timing
- All outputs are registered except cfg_ready, which is decoded combinationally from state.
- Reset values:
  - state IDLE; rate 1; log2_d 0; q 1; n 1
  - in_en, dec_en, out_valid, cic_clr, cfg_err, busy: 0
  - cfg_ready: 1
- Cycle 1 is the first cycle in SETTLE, with phase=0.
- in_en is high in cycles 3, 6, 9, …
- dec_en is high in cycles 3R, 6R, …, always coincident with an in_en.
- With R=1, dec_en equals in_en.
- First out_valid in RUN: cycle 3R·(settle+1).
- DRAIN lasts until the current frame's dec_en, at most 3R cycles. FLUSH lasts exactly CLK_DIV cycles.
- rst asserted mid-operation: all outputs take their reset values on the next edge and any pending rate is lost.

## Structure
- The shared package cic_pkg holds:
  - the state enum
  - the legal-rate check function
  - the rate-lookup function returning {log2_d, q, n, settle}
  - the CLK_DIV default
- Sub-module cic_strobe_gen holds the phase counter and sample counter. Its inputs are run, clr and rate; its outputs are in_en and dec_en. The top level holds the FSM, the config handshake and settle_cnt.

## Test plan
- Reset, then enable=1 with R=1 → in_en every 3 cycles from cycle 3; first out_valid at cycle 6; then out_valid every 3 cycles.
- In RUN at R=1, request R=8 → DRAIN, then 3 cycles of cic_clr; rate=8, log2_d=5, q=5, n=5; dec_en every 24 cycles; first out_valid 24·26=624 cycles after SETTLE entry.
- cfg_rate=5 in RUN → cfg_err pulses one cycle; rate unchanged; out_valid cadence undisturbed.
- cfg_valid held during DRAIN/FLUSH → cfg_ready=0 there; the request is accepted in the first SETTLE cycle.
- In IDLE, request R=16 → log2_d=7, q=5, n=7 on the next cycle, no cic_clr; enable → dec_en every 48 cycles, settle of 35 dec_en pulses.
- rst mid-DRAIN → all outputs at reset values on the next cycle; the pending rate is discarded and rate=1.

Source files
------------

// File: rtl/cic_pkg.sv
// CIC decimator rate controller: shared types, constants and rate table.
// Imported by the interface, the strobe generator and the controller top.
package cic_pkg;

   localparam int CLK_DIV_DEF = 3;
   localparam int RATE_W      = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RUN,
      ST_DRAIN,
      ST_FLUSH
   } state_t;

   typedef struct packed {
      logic [2:0] log2_d;
      logic [2:0] q;
      logic [2:0] n;
      logic [5:0] settle;
   } rate_cfg_t;

   function automatic logic rate_legal(input logic [RATE_W-1:0] r);
      return r inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
   endfunction

   // settle is the comb refill time Q*N in decimated samples
   function automatic rate_cfg_t rate_lookup(input logic [RATE_W-1:0] r);
      rate_cfg_t c;
      c = '{log2_d: 3'd0, q: 3'd1, n: 3'd1, settle: 6'd1};
      unique case (r)
         5'd2:    c = '{log2_d: 3'd2, q: 3'd4, n: 3'd2, settle: 6'd8};
         5'd4:    c = '{log2_d: 3'd4, q: 3'd3, n: 3'd4, settle: 6'd12};
         5'd8:    c = '{log2_d: 3'd5, q: 3'd5, n: 3'd5, settle: 6'd25};
         5'd16:   c = '{log2_d: 3'd7, q: 3'd5, n: 3'd7, settle: 6'd35};
         default: c = '{log2_d: 3'd0, q: 3'd1, n: 3'd1, settle: 6'd1};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cic_rate_ctrl_if.sv
// Rate-change request handshake between a host and the CIC controller.
// A request is taken on a cycle where cfg_valid and cfg_ready are both high.
interface cic_rate_ctrl_if;
   import cic_pkg::*;

   logic              cfg_valid;
   logic [RATE_W-1:0] cfg_rate;
   logic              cfg_ready;
   logic              cfg_err;

   modport master (
      output cfg_valid,
      output cfg_rate,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_rate,
      output cfg_ready,
      output cfg_err
   );

endinterface

// File: rtl/cic_strobe_gen.sv
// Input-sample and decimated-sample strobe generator for the CIC filter.
// Strobes are registered; dec_nxt exposes the value dec_en takes next cycle.
module cic_strobe_gen
   import cic_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              clr,
   input  logic [RATE_W-1:0] rate,
   output logic              in_en,
   output logic              dec_en,
   output logic              dec_nxt
);

   localparam logic [1:0] PH_LAST = 2'(CLK_DIV - 1);

   logic [1:0] phase;
   logic [1:0] phase_n;
   logic [3:0] sample_cnt;
   logic [3:0] r_last;
   logic       ph_last;
   logic       in_nxt;

   assign r_last  = 4'(rate - 5'd1);
   assign ph_last = (phase == PH_LAST);
   assign phase_n = ph_last ? 2'd0 : phase + 2'd1;

   // Look one cycle ahead so the registered strobes land on the last phase
   assign in_nxt  = run && !clr && (phase_n == PH_LAST);
   assign dec_nxt = in_nxt && (sample_cnt == r_last);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         phase      <= 2'd0;
         sample_cnt <= 4'd0;
         in_en      <= 1'b0;
         dec_en     <= 1'b0;
      end else begin
         in_en  <= in_nxt;
         dec_en <= dec_nxt;
         if (run) begin
            phase <= phase_n;
            if (ph_last)
               sample_cnt <= (sample_cnt == r_last) ? 4'd0 : sample_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/cic_rate_ctrl.sv
// CIC decimator sequencer: owns rate R, derives datapath constants and
// sequences rate changes through drain, clear and comb refill.
module cic_rate_ctrl
   import cic_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   cic_rate_ctrl_if.slave    cfg,
   output logic [RATE_W-1:0] rate,
   output logic [2:0]        log2_d,
   output logic [2:0]        q,
   output logic [2:0]        n,
   output logic              in_en,
   output logic              dec_en,
   output logic              out_valid,
   output logic              cic_clr,
   output logic              busy
);

   state_t            state;
   state_t            state_n;
   rate_cfg_t         cur;
   logic [RATE_W-1:0] pend;
   logic [5:0]        settle_cnt;
   logic [1:0]        fl_cnt;
   logic              acc;
   logic              acc_ok;
   logic              acc_bad;
   logic              settle_hit;
   logic              fl_last;
   logic              apply_now;
   logic              apply_pend;
   logic              run;
   logic              clr;
   logic              dec_nxt;

   assign cfg.cfg_ready = (state == ST_IDLE) || (state == ST_SETTLE) ||
                          (state == ST_RUN);

   assign acc        = cfg.cfg_valid && cfg.cfg_ready;
   assign acc_ok     = acc && rate_legal(cfg.cfg_rate);
   assign acc_bad    = acc && !rate_legal(cfg.cfg_rate);
   assign settle_hit = ((settle_cnt + 6'd1) == cur.settle);
   assign fl_last    = (fl_cnt == 2'(CLK_DIV - 1));

   // Requests seen with the run request dropping take effect as in IDLE
   assign apply_now  = acc_ok && ((state == ST_IDLE) || !enable);
   assign apply_pend = (state == ST_DRAIN) && (state_n != ST_DRAIN);

   assign run = (state == ST_SETTLE) || (state == ST_RUN) ||
                (state == ST_DRAIN);
   assign clr = (state_n == ST_IDLE) || (state_n == ST_FLUSH);

   assign log2_d = cur.log2_d;
   assign q      = cur.q;
   assign n      = cur.n;

   always_comb begin
      state_n = state;
      if (!enable) begin
         state_n = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:
               if (!acc) state_n = ST_SETTLE;
            ST_SETTLE:
               if (acc_ok) state_n = ST_DRAIN;
               else if (dec_en && settle_hit) state_n = ST_RUN;
            ST_RUN:
               if (acc_ok) state_n = ST_DRAIN;
            ST_DRAIN:
               if (dec_en) state_n = ST_FLUSH;
            ST_FLUSH:
               if (fl_last) state_n = ST_SETTLE;
            default:
               state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rate        <= 5'd1;
         cur         <= rate_lookup(5'd1);
         pend        <= 5'd1;
         settle_cnt  <= 6'd0;
         fl_cnt      <= 2'd0;
         out_valid   <= 1'b0;
         cic_clr     <= 1'b0;
         busy        <= 1'b0;
         cfg.cfg_err <= 1'b0;
      end else begin
         state       <= state_n;
         cfg.cfg_err <= acc_bad;
         out_valid   <= (state_n == ST_RUN) && dec_nxt;
         cic_clr     <= (state_n == ST_FLUSH);
         busy        <= (state_n == ST_DRAIN) || (state_n == ST_FLUSH);

         if ((state == ST_FLUSH) && (state_n == ST_FLUSH))
            fl_cnt <= fl_cnt + 2'd1;
         else
            fl_cnt <= 2'd0;

         if ((state != ST_SETTLE) || (state_n != ST_SETTLE))
            settle_cnt <= 6'd0;
         else if (dec_en)
            settle_cnt <= settle_cnt + 6'd1;

         if (acc_ok)
            pend <= cfg.cfg_rate;

         if (apply_now) begin
            rate <= cfg.cfg_rate;
            cur  <= rate_lookup(cfg.cfg_rate);
         end else if (apply_pend) begin
            rate <= pend;
            cur  <= rate_lookup(pend);
         end
      end
   end

   cic_strobe_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_strobe (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .clr     (clr),
      .rate    (rate),
      .in_en   (in_en),
      .dec_en  (dec_en),
      .dec_nxt (dec_nxt)
   );

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl: strobe cadence, settle timing,
// rate-change sequencing, illegal rates and reset during drain.
module tb_cic_rate_ctrl;
   import cic_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [4:0] rate;
   logic [2:0] log2_d;
   logic [2:0] q;
   logic [2:0] n;
   logic       in_en;
   logic       dec_en;
   logic       out_valid;
   logic       cic_clr;
   logic       busy;

   int vecs = 0;
   int errs = 0;

   cic_rate_ctrl_if cfg ();

   cic_rate_ctrl #(
      .CLK_DIV (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .cfg       (cfg),
      .rate      (rate),
      .log2_d    (log2_d),
      .q         (q),
      .n         (n),
      .in_en     (in_en),
      .dec_en    (dec_en),
      .out_valid (out_valid),
      .cic_clr   (cic_clr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [20:0] got;
      rst = 1'b1;
      enable = 1'b0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_rate = 5'd1;
      tick();
      tick();
      got = {rate, log2_d, q, n, in_en, dec_en, out_valid, cic_clr,
             cfg.cfg_err, busy, cfg.cfg_ready};
      vecs++;
      if (got !== {5'd1, 3'd0, 3'd1, 3'd1, 7'b0000001}) begin
         errs++;
         $display("FAIL reset_state: got %h want %h", got,
                  {5'd1, 3'd0, 3'd1, 3'd1, 7'b0000001});
      end
      rst = 1'b0;
   endtask

   // R=1 from reset: in_en every 3 cycles, first out_valid at cycle 6
   task automatic test_r1_cadence();
      logic [2:0] exp;
      enable = 1'b1;
      tick();
      for (int k = 1; k <= 30; k++) begin
         exp = {k % 3 == 0, k % 3 == 0, (k >= 6) && (k % 3 == 0)};
         vecs++;
         if ({in_en, dec_en, out_valid} !== exp) begin
            errs++;
            $display("FAIL r1_cadence k=%0d: got %b want %b", k,
                     {in_en, dec_en, out_valid}, exp);
         end
         tick();
      end
   endtask

   // Illegal rate in RUN at cycle 31
   task automatic test_bad_rate();
      logic [1:0] exp;
      cfg.cfg_valid = 1'b1;
      cfg.cfg_rate = 5'd5;
      tick();
      cfg.cfg_valid = 1'b0;
      for (int k = 32; k <= 40; k++) begin
         exp = {k == 32, (k % 3 == 0)};
         vecs++;
         if ({cfg.cfg_err, out_valid} !== exp || rate !== 5'd1) begin
            errs++;
            $display("FAIL bad_rate k=%0d: got err/ov %b rate %0d want %b rate 1",
                     k, {cfg.cfg_err, out_valid}, rate, exp);
         end
         tick();
      end
   endtask

   // RUN at R=1, cycle 41: request R=8
   task automatic test_rate_change();
      logic [2:0] exp;
      cfg.cfg_valid = 1'b1;
      cfg.cfg_rate = 5'd8;
      vecs++;
      if (cfg.cfg_ready !== 1'b1) begin
         errs++;
         $display("FAIL run_ready: got %b want 1", cfg.cfg_ready);
      end
      tick();
      cfg.cfg_valid = 1'b0;
      vecs++;
      if ({busy, cfg.cfg_ready, dec_en, out_valid, rate} !== {4'b1010, 5'd1}) begin
         errs++;
         $display("FAIL drain_cycle: got %b/%0d want 1010/1",
                  {busy, cfg.cfg_ready, dec_en, out_valid}, rate);
      end
      tick();
      for (int f = 0; f < 3; f++) begin
         vecs++;
         if ({cic_clr, busy, in_en} !== 3'b110 ||
             {rate, log2_d, q, n} !== {5'd8, 3'd5, 3'd5, 3'd5}) begin
            errs++;
            $display("FAIL flush_r8 f=%0d: got clr/busy/in %b cfg %0d/%0d/%0d/%0d want 110 8/5/5/5",
                     f, {cic_clr, busy, in_en}, rate, log2_d, q, n);
         end
         tick();
      end
      for (int k = 1; k <= 630; k++) begin
         exp = {k % 3 == 0, k % 24 == 0, (k >= 624) && (k % 24 == 0)};
         vecs++;
         if ({in_en, dec_en, out_valid, cic_clr, busy} !== {exp, 2'b00}) begin
            errs++;
            $display("FAIL r8_settle k=%0d: got %b want %b", k,
                     {in_en, dec_en, out_valid, cic_clr, busy}, {exp, 2'b00});
         end
         tick();
      end
   endtask

   // RUN at R=8, cycle 631: request R=2 and hold cfg_valid through DRAIN/FLUSH
   task automatic test_hold_in_drain();
      logic [2:0] exp;
      cfg.cfg_valid = 1'b1;
      cfg.cfg_rate = 5'd2;
      tick();
      for (int k = 632; k <= 648; k++) begin
         vecs++;
         if ({cfg.cfg_ready, busy, dec_en, out_valid} !== {2'b01, k == 648, 1'b0}) begin
            errs++;
            $display("FAIL hold_drain k=%0d: got %b want %b", k,
                     {cfg.cfg_ready, busy, dec_en, out_valid}, {2'b01, k == 648, 1'b0});
         end
         tick();
      end
      for (int f = 0; f < 3; f++) begin
         vecs++;
         if ({cfg.cfg_ready, cic_clr} !== 2'b01 || rate !== 5'd2) begin
            errs++;
            $display("FAIL hold_flush f=%0d: got %b rate %0d want 01 rate 2",
                     f, {cfg.cfg_ready, cic_clr}, rate);
         end
         tick();
      end
      vecs++;
      if ({cfg.cfg_ready, busy, cic_clr} !== 3'b100) begin
         errs++;
         $display("FAIL hold_settle1: got %b want 100", {cfg.cfg_ready, busy, cic_clr});
      end
      tick();
      cfg.cfg_valid = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         vecs++;
         if ({busy, cic_clr, dec_en, out_valid} !== {2'b10, k == 6, 1'b0}) begin
            errs++;
            $display("FAIL same_rate_drain k=%0d: got %b want %b", k,
                     {busy, cic_clr, dec_en, out_valid}, {2'b10, k == 6, 1'b0});
         end
         tick();
      end
      for (int k = 7; k <= 9; k++) begin
         vecs++;
         if ({busy, cic_clr} !== 2'b11) begin
            errs++;
            $display("FAIL same_rate_flush k=%0d: got %b want 11", k, {busy, cic_clr});
         end
         tick();
      end
      for (int k = 1; k <= 60; k++) begin
         exp = {k % 3 == 0, k % 6 == 0, (k >= 54) && (k % 6 == 0)};
         vecs++;
         if ({in_en, dec_en, out_valid} !== exp || log2_d !== 3'd2) begin
            errs++;
            $display("FAIL r2_settle k=%0d: got %b l2d %0d want %b l2d 2", k,
                     {in_en, dec_en, out_valid}, log2_d, exp);
         end
         tick();
      end
   endtask

   // Disable, configure R=16 while idle, then run through the long settle
   task automatic test_idle_r16();
      logic [2:0] exp;
      enable = 1'b0;
      tick();
      vecs++;
      if ({in_en, dec_en, out_valid, busy, cfg.cfg_ready} !== 5'b00001) begin
         errs++;
         $display("FAIL idle_entry: got %b want 00001",
                  {in_en, dec_en, out_valid, busy, cfg.cfg_ready});
      end
      cfg.cfg_valid = 1'b1;
      cfg.cfg_rate = 5'd16;
      tick();
      cfg.cfg_valid = 1'b0;
      vecs++;
      if ({rate, log2_d, q, n} !== {5'd16, 3'd7, 3'd5, 3'd7} ||
          {cic_clr, cfg.cfg_err, busy} !== 3'b000) begin
         errs++;
         $display("FAIL idle_cfg16: got %0d/%0d/%0d/%0d clr/err/busy %b want 16/7/5/7 000",
                  rate, log2_d, q, n, {cic_clr, cfg.cfg_err, busy});
      end
      enable = 1'b1;
      tick();
      for (int k = 1; k <= 1730; k++) begin
         exp = {k % 3 == 0, k % 48 == 0, (k >= 1728) && (k % 48 == 0)};
         vecs++;
         if ({in_en, dec_en, out_valid, cic_clr} !== {exp, 1'b0}) begin
            errs++;
            $display("FAIL r16_settle k=%0d: got %b want %b", k,
                     {in_en, dec_en, out_valid, cic_clr}, {exp, 1'b0});
         end
         tick();
      end
   endtask

   // RUN at R=16: request R=4, then reset while draining
   task automatic test_rst_in_drain();
      logic [20:0] got;
      cfg.cfg_valid = 1'b1;
      cfg.cfg_rate = 5'd4;
      tick();
      cfg.cfg_valid = 1'b0;
      tick();
      vecs++;
      if ({busy, cfg.cfg_ready} !== 2'b10 || rate !== 5'd16) begin
         errs++;
         $display("FAIL pre_rst_drain: got %b rate %0d want 10 rate 16",
                  {busy, cfg.cfg_ready}, rate);
      end
      rst = 1'b1;
      tick();
      got = {rate, log2_d, q, n, in_en, dec_en, out_valid, cic_clr,
             cfg.cfg_err, busy, cfg.cfg_ready};
      vecs++;
      if (got !== {5'd1, 3'd0, 3'd1, 3'd1, 7'b0000001}) begin
         errs++;
         $display("FAIL rst_mid_drain: got %h want %h", got,
                  {5'd1, 3'd0, 3'd1, 3'd1, 7'b0000001});
      end
      rst = 1'b0;
      tick();
      for (int k = 1; k <= 9; k++) begin
         vecs++;
         if ({in_en, dec_en} !== {k % 3 == 0, k % 3 == 0} || rate !== 5'd1) begin
            errs++;
            $display("FAIL post_rst k=%0d: got %b rate %0d want %b rate 1", k,
                     {in_en, dec_en}, rate, {k % 3 == 0, k % 3 == 0});
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_r1_cadence();
      test_bad_rate();
      test_rate_change();
      test_hold_in_drain();
      test_idle_r16();
      test_rst_in_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
